// File: rtl/user_id_readout.sv
// Multi-word user project ID: tie-cell constants captured after reset, served over a
// valid/ready word-read port and a serial dump. Optional feature macro: USER_ID_PARITY_EN.
module user_id_readout #(
    parameter int NUM_WORDS = 4,
    parameter int WORD_W = 32,
    parameter logic [NUM_WORDS*WORD_W-1:0] ID_VALUE = '0,
    parameter int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [IDX_W-1:0]  req_idx_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [WORD_W-1:0] rsp_data_o,
    output logic              rsp_err_o,
    input  logic              shift_start_i,
    output logic              shift_busy_o,
    output logic              shift_out_o,
    output logic              shift_done_o,
    output logic              id_valid_o
`ifdef USER_ID_PARITY_EN
    ,
    output logic              rsp_parity_o
`endif
);

`ifdef USER_ID_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int FRAME_W = WORD_W + PAR_W;
    localparam int BIT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(NUM_WORDS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

    // Handshakes: a transfer happens on the rising edge where valid && ready are both 1;
    // valid and its payload are held stable until that edge, and ready never depends on valid.

    typedef enum logic [1:0] {CAPTURE, IDLE, RESP, SHIFT} state_t;

    state_t state, next_state;

    logic [WORD_W-1:0]  tie_word [NUM_WORDS];
    logic [WORD_W-1:0]  bank [NUM_WORDS];
    logic [IDX_W-1:0]   cap_idx;
    logic [IDX_W-1:0]   word_cnt;
    logic [IDX_W-1:0]   word_nxt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] sreg;
    logic [FRAME_W-1:0] first_frame;
    logic [FRAME_W-1:0] next_frame;
    logic               idx_ok;

    // Each bit models a conb_1 tie cell whose HI or LO output is chosen by ID_VALUE.
    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_tie
        assign tie_word[k] = ID_VALUE[k*WORD_W +: WORD_W];
    end

    function automatic logic [FRAME_W-1:0] frame(input logic [WORD_W-1:0] w);
`ifdef USER_ID_PARITY_EN
        return {^w, w};
`else
        return w;
`endif
    endfunction

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= CAPTURE;
        else          state <= next_state;
    end

    always_comb begin
        next_state  = state;
        req_ready_o = (state == IDLE);
        word_nxt    = word_cnt + IDX_W'(1);
        idx_ok      = ({1'b0, req_idx_i} < (IDX_W+1)'(NUM_WORDS));
        first_frame = frame(bank[0]);
        next_frame  = frame(bank[word_nxt]);
        case (state)
            CAPTURE: if (cap_idx == WORD_LAST) next_state = IDLE;
            IDLE: begin
                // A read request takes priority over a simultaneous dump request.
                if (req_valid_i)        next_state = RESP;
                else if (shift_start_i) next_state = SHIFT;
            end
            RESP:  if (rsp_ready_i) next_state = IDLE;
            SHIFT: if (bit_cnt == BIT_LAST && word_cnt == WORD_LAST) next_state = IDLE;
            default: next_state = CAPTURE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int k = 0; k < NUM_WORDS; k++) bank[k] <= '0;
            cap_idx      <= '0;
            word_cnt     <= '0;
            bit_cnt      <= '0;
            sreg         <= '0;
            id_valid_o   <= 1'b0;
            rsp_valid_o  <= 1'b0;
            rsp_data_o   <= '0;
            rsp_err_o    <= 1'b0;
            shift_busy_o <= 1'b0;
            shift_out_o  <= 1'b0;
            shift_done_o <= 1'b0;
`ifdef USER_ID_PARITY_EN
            rsp_parity_o <= 1'b0;
`endif
        end else begin
            shift_done_o <= 1'b0;
            case (state)
                CAPTURE: begin
                    bank[cap_idx] <= tie_word[cap_idx];
                    cap_idx       <= cap_idx + IDX_W'(1);
                    if (cap_idx == WORD_LAST) id_valid_o <= 1'b1;
                end
                IDLE: begin
                    if (req_valid_i) begin
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= ~idx_ok;
                        rsp_data_o  <= idx_ok ? bank[req_idx_i] : '0;
`ifdef USER_ID_PARITY_EN
                        rsp_parity_o <= idx_ok ? ^bank[req_idx_i] : 1'b0;
`endif
                    end else if (shift_start_i) begin
                        // Bit 0 of word 0 is presented during the first SHIFT cycle.
                        shift_busy_o <= 1'b1;
                        shift_out_o  <= first_frame[0];
                        sreg         <= first_frame >> 1;
                        word_cnt     <= '0;
                        bit_cnt      <= '0;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        rsp_err_o   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (word_cnt == WORD_LAST) begin
                            shift_busy_o <= 1'b0;
                            shift_out_o  <= 1'b0;
                            shift_done_o <= 1'b1;
                            word_cnt     <= '0;
                        end else begin
                            word_cnt    <= word_nxt;
                            shift_out_o <= next_frame[0];
                            sreg        <= next_frame >> 1;
                        end
                    end else begin
                        bit_cnt     <= bit_cnt + BIT_W'(1);
                        shift_out_o <= sreg[0];
                        sreg        <= sreg >> 1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
